// File: rtl/load_store_pkg.sv
// rtl/load_store_pkg.sv - shared size, state and byte-mask encodings for the load/store unit
package load_store_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_ILL  = 2'd3;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_mask = MASK_BYTE;
            SIZE_HALF: size_mask = MASK_HALF;
            SIZE_WORD: size_mask = MASK_WORD;
            default:   size_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane steering: strobes, store shift, load extract/extend, fault check
module lsu_lane_align
    import load_store_pkg::*;
(
    input  logic [1:0]  i_chk_size,
    input  logic [1:0]  i_chk_addr_lo,
    output logic        o_fault,
    input  logic [1:0]  i_size,
    input  logic        i_zero_ext,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [4:0]  w_bit_shift;
    logic [31:0] w_rdata_lane;

    assign w_bit_shift  = {i_addr_lo, 3'b000};
    assign w_rdata_lane = i_rdata >> w_bit_shift;
    assign o_wdata      = i_wdata << w_bit_shift;
    assign o_wstrb      = size_mask(i_size) << i_addr_lo;

    // Checked against the incoming request, not the captured one, so a fault is known at accept
    always_comb begin
        o_fault = 1'b0;
        case (i_chk_size)
            SIZE_HALF: o_fault = i_chk_addr_lo[0];
            SIZE_WORD: o_fault = (i_chk_addr_lo != 2'b00);
            SIZE_ILL:  o_fault = 1'b1;
            default:   o_fault = 1'b0;
        endcase
    end

    always_comb begin
        o_rdata = w_rdata_lane;
        case (i_size)
            SIZE_BYTE: o_rdata = {{24{~i_zero_ext & w_rdata_lane[7]}}, w_rdata_lane[7:0]};
            SIZE_HALF: o_rdata = {{16{~i_zero_ext & w_rdata_lane[15]}}, w_rdata_lane[15:0]};
            default:   o_rdata = w_rdata_lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store initiator: request capture, wait counter, response hold
module load_store_unit
    import load_store_pkg::*;
#(
    parameter int pWaitCycles = 0
)(
    input  logic        iwClk,
    input  logic        iwnRst,
    input  logic        iwReqValid,
    output logic        owReqReady,
    input  logic        iwReqWrite,
    input  logic [1:0]  iwReqSize,
    input  logic        iwReqUnsigned,
    input  logic [31:0] iwReqAddr,
    input  logic [31:0] iwReqWdata,
    output logic        owRspValid,
    input  logic        iwRspReady,
    output logic [31:0] owRspData,
    output logic        owRspFault,
    output logic [31:0] owMemReadAddr,
    input  logic [31:0] iwMemReadData,
    output logic [31:0] owMemWriteAddr,
    output logic [31:0] owMemWriteData,
    output logic [3:0]  owMemWstrb
);

    localparam logic [3:0] LP_WAIT_INIT = 4'(pWaitCycles);

    lsu_state_t  r_state;
    lsu_state_t  w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic        r_zext;
    logic [1:0]  r_size;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_wdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_rsp_data;
    logic        r_rsp_fault;

    logic        w_accept;
    logic        w_wait_done;
    logic        w_req_fault;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata_lane;
    logic [31:0] w_rdata_ext;

    lsu_lane_align u_lane_align (
        .i_chk_size    (iwReqSize),
        .i_chk_addr_lo (iwReqAddr[1:0]),
        .o_fault       (w_req_fault),
        .i_size        (r_size),
        .i_zero_ext    (r_zext),
        .i_addr_lo     (r_addr_lo),
        .i_wdata       (r_wdata),
        .i_rdata       (iwMemReadData),
        .o_wstrb       (w_wstrb),
        .o_wdata       (w_wdata_lane),
        .o_rdata       (w_rdata_ext)
    );

    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        owReqReady  = 1'b0;
        owRspValid  = 1'b0;
        w_accept    = 1'b0;
        w_wait_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                owReqReady = 1'b1;
                if (iwReqValid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_req_fault ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_wait_done = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                owRspValid = 1'b1;
                if (iwRspReady) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Memory address only moves for requests that will touch memory; it holds otherwise
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_zext      <= 1'b0;
            r_size      <= 2'd0;
            r_addr_lo   <= 2'd0;
            r_wdata     <= 32'd0;
            r_mem_addr  <= 32'd0;
            r_rsp_data  <= 32'd0;
            r_rsp_fault <= 1'b0;
        end else if (w_accept) begin
            r_write     <= iwReqWrite;
            r_zext      <= iwReqUnsigned;
            r_size      <= iwReqSize;
            r_addr_lo   <= iwReqAddr[1:0];
            r_wdata     <= iwReqWdata;
            r_rsp_data  <= 32'd0;
            r_rsp_fault <= w_req_fault;
            if (!w_req_fault) begin
                r_cnt      <= LP_WAIT_INIT;
                r_mem_addr <= {iwReqAddr[31:2], 2'b00};
            end
        end else if (r_state == ST_WAIT) begin
            if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end else if (!r_write) begin
                r_rsp_data <= w_rdata_ext;
            end
        end
    end

    assign owMemWstrb     = (w_wait_done && r_write) ? w_wstrb : 4'b0000;
    assign owMemReadAddr  = r_mem_addr;
    assign owMemWriteAddr = r_mem_addr;
    assign owMemWriteData = w_wdata_lane;
    assign owRspData      = r_rsp_data;
    assign owRspFault     = r_rsp_fault;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Pipeline-side initiator for the byte-addressed data memory port: address, write data, byte write strobes (4 bits), and a little-endian combinational read word.
- Accepts one load/store request per valid/ready handshake.
- Aligns addresses to words and generates byte strobes with lane-shifted write data.
- Extracts and sign/zero-extends load data and flags misaligned accesses.
- Returns one response per request through a valid/ready handshake.

Parameters:
pWaitCycles, 0, extra cycles in WAIT before the memory access completes (0..15).

Ports:
iwClk  input  1  clock; all state updates on posedge.
iwnRst  input  1  reset, asynchronous, active-low.
iwReqValid  input  1  request valid.
owReqReady  output  1  request accepted when high with iwReqValid.
iwReqWrite  input  1  1 = store, 0 = load.
iwReqSize  input  2  0 byte, 1 half, 2 word, 3 illegal.
iwReqUnsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
iwReqAddr  input  32  byte address.
iwReqWdata  input  32  store data, right-justified.
owRspValid  output  1  response valid.
iwRspReady  input  1  response consumed when high with owRspValid.
owRspData  output  32  extended load data; 0 for stores and faults.
owRspFault  output  1  misaligned or illegal-size request.
owMemReadAddr  output  32  word-aligned read address.
iwMemReadData  input  32  little-endian word at owMemReadAddr.
owMemWriteAddr  output  32  word-aligned write address.
owMemWriteData  output  32  lane-shifted store data.
owMemWstrb  output  4  byte write strobes.

Behaviour:
- Clock and reset: one clock, iwClk. Reset iwnRst is asynchronous, active-low.
- Reset values: state IDLE, wait counter 0, all captured registers 0.
  - owReqReady = 1 (IDLE).
  - owRspValid, owRspFault, owRspData, owMem* all 0.
- States: IDLE, WAIT, RESP. owReqReady = (state == IDLE).
- IDLE, on iwReqValid:
  - Capture write, size, unsigned, addr and wdata.
  - Fault if size == 3, or size == 1 with addr[0] = 1, or size == 2 with addr[1:0] != 0.
  - Fault: go to RESP with fault = 1 and data = 0. No memory access; strobes stay 0.
  - Otherwise: load the counter with pWaitCycles and go to WAIT.
- WAIT:
  - owMemReadAddr and owMemWriteAddr = {addr[31:2], 2'b00}.
  - If counter != 0: decrement it.
  - If counter == 0, store: owMemWstrb = mask << addr[1:0], where mask is 0001, 0011 or 1111 by size. Strobes are asserted in this single cycle only. Go to RESP.
  - If counter == 0, load: sample iwMemReadData >> (8 * addr[1:0]) at the posedge. Take bits [7:0] or [15:0] and extend per unsigned; a word is used as-is. Go to RESP.
- owMemWriteData = wdata << (8 * addr[1:0]), held from accept through WAIT.
- owMemWstrb is 0 in every state and cycle other than the final WAIT cycle of a store.
- RESP: owRspValid = 1 and data/fault are held stable until iwRspReady. Then go to IDLE with owRspValid low.
- Latency, pWaitCycles = 0:
  - Accept edge N, WAIT during cycle N+1, owRspValid from cycle N+2.
  - Zero-backpressure throughput: one request per 3 cycles.
  - General case: response valid 2 + pWaitCycles cycles after acceptance.
- owMemReadAddr holds its last value outside WAIT; the memory read is side-effect free.
- Reset mid-operation: state returns to IDLE immediately and owMemWstrb drops to 0 asynchronously. The in-flight request is discarded with no response.
- Address arithmetic is 32-bit with no wrap checks; the word-aligned address never carries.

Decomposition:
- Shared package load_store_pkg holds:
  - size encodings: SIZE_BYTE = 0, SIZE_HALF = 1, SIZE_WORD = 2;
  - state encodings: ST_IDLE, ST_WAIT, ST_RESP;
  - byte mask constants.
- One combinational sub-module, lsu_lane_align, holds:
  - strobe and write-data shift generation;
  - read-lane extract and extend;
  - misalign detection.
- The top level contains the FSM, counter and registers.

Test Plan:
- Bench memory is a little-endian byte array with word-aligned access. In every scenario, fault rows must leave owMemWstrb at 0 in all cycles.
- SB addr 0x101 wdata 0x000000AB -> one cycle with owMemWstrb 4'b0010, write addr 0x100, write data 0x0000AB00. Response: data 0, fault 0. Word 0x100 otherwise unchanged.
- Word 0x100 = 0x80FF1234, then:
  - LB 0x103 -> 0xFFFFFF80.
  - LBU 0x103 -> 0x00000080.
  - LH 0x102 -> 0xFFFF80FF.
  - LHU 0x100 -> 0x00001234.
  - LW 0x100 -> 0x80FF1234.
- LW 0x102, SH 0x101, and size 3 at 0x100 -> each gives owRspFault = 1 with data 0, and memory is unchanged.
- Backpressure: iwRspReady low for 5 cycles -> owRspValid, data and fault held stable; owReqReady low until the handshake. A new request is accepted the cycle after the handshake.
- pWaitCycles = 2, SW 0x10 of 0xDEADBEEF accepted at edge N -> owMemWstrb 4'b1111 only in cycle N+3. owRspValid at N+4; readback returns 0xDEADBEEF.
- Reset asserted during the WAIT of an SW -> owMemWstrb 0 immediately and no response. After release: owReqReady = 1, outputs at reset values, target word unchanged.
